cfg_loader: RTL

- Upstream stage of the PE-array top. It turns a word-serial configuration stream into the four parallel config fields: cfg_data_data, cfg_wicp_data, cfg_tmpc_data and cfg_post_data.
- It issues them with the cfg_valid / cfg_busy handshake that the array top consumes.
- Assembly happens in shadow registers, so the next frame can load while the array is still busy with the current configuration.

---
 rtl/cfg_loader_pkg.sv | 27 ++
 rtl/cfg_loader_if.sv | 32 +++
 rtl/cfg_loader_field_shift.sv | 40 ++++
 rtl/cfg_loader.sv | 112 +++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared state encoding and field-offset helpers for cfg_loader
package cfg_loader_pkg;

   typedef enum logic {
      LOAD  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam int DATA_OFF = 0;

   function automatic int cdiv(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int wicp_off(input int dw);
      return dw;
   endfunction

   function automatic int tmpc_off(input int dw, input int ww);
      return dw + ww;
   endfunction

   function automatic int post_off(input int dw, input int ww, input int tw);
      return dw + ww + tw;
   endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// rtl/cfg_loader_if.sv - stream input and config-issue bundle for cfg_loader
interface cfg_loader_if #(
   parameter int IWIDTH      = 32,
   parameter int DATA_CWIDTH = 64,
   parameter int WICP_CWIDTH = 32,
   parameter int TMPC_CWIDTH = 32,
   parameter int POST_CWIDTH = 16
) ();
   logic                   in_valid;
   logic                   in_ready;
   logic [IWIDTH-1:0]      in_data;
   logic                   in_last;
   logic                   cfg_valid;
   logic                   cfg_busy;
   logic [DATA_CWIDTH-1:0] cfg_data_data;
   logic [WICP_CWIDTH-1:0] cfg_wicp_data;
   logic [TMPC_CWIDTH-1:0] cfg_tmpc_data;
   logic [POST_CWIDTH-1:0] cfg_post_data;
   logic                   frame_err;

   modport master (
      output in_valid, in_data, in_last, cfg_busy,
      input  in_ready, cfg_valid, cfg_data_data, cfg_wicp_data,
             cfg_tmpc_data, cfg_post_data, frame_err
   );

   modport slave (
      input  in_valid, in_data, in_last, cfg_busy,
      output in_ready, cfg_valid, cfg_data_data, cfg_wicp_data,
             cfg_tmpc_data, cfg_post_data, frame_err
   );
endinterface

// File: rtl/cfg_loader_field_shift.sv
// rtl/cfg_loader_field_shift.sv - one field's shadow register, written word by word
// The word whose global index equals OFF+w lands in slice w; excess top bits are dropped.
module cfg_field_shift #(
   parameter int FWIDTH = 32,
   parameter int IWIDTH = 32,
   parameter int OFF    = 0,
   parameter int CW     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [CW-1:0]     i_cnt,
   input  logic [IWIDTH-1:0] i_data,
   output logic [FWIDTH-1:0] o_q
);
   localparam int NW = (FWIDTH + IWIDTH - 1) / IWIDTH;

   logic w_unused;
   assign w_unused = ^i_data;

   for (genvar w = 0; w < NW; w++) begin : g_word
      localparam int LO = w * IWIDTH;
      localparam int SW = ((FWIDTH - LO) < IWIDTH) ? (FWIDTH - LO) : IWIDTH;

      logic [SW-1:0] r_w;
      logic          w_sel;

      assign w_sel = i_we && (i_cnt == CW'(OFF + w));

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_w <= '0;
         end else if (w_sel) begin
            r_w <= i_data[SW-1:0];
         end
      end

      assign o_q[LO +: SW] = r_w;
   end
endmodule

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - word-serial config stream to parallel cfg fields with busy-gated issue
module cfg_loader
   import cfg_loader_pkg::*;
#(
   parameter int IWIDTH      = 32,
   parameter int DATA_CWIDTH = 64,
   parameter int WICP_CWIDTH = 32,
   parameter int TMPC_CWIDTH = 32,
   parameter int POST_CWIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   cfg_loader_if.slave  bus
);
   localparam int DW = cdiv(DATA_CWIDTH, IWIDTH);
   localparam int WW = cdiv(WICP_CWIDTH, IWIDTH);
   localparam int TW = cdiv(TMPC_CWIDTH, IWIDTH);
   localparam int PW = cdiv(POST_CWIDTH, IWIDTH);
   localparam int N  = DW + WW + TW + PW;
   localparam int CW = $clog2(N + 1);

   state_t                 r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic                   r_in_ready, r_cfg_valid, r_frame_err;
   logic                   w_acc, w_we, w_err_nxt, w_issue;
   logic [DATA_CWIDTH-1:0] r_data, w_sh_data;
   logic [WICP_CWIDTH-1:0] r_wicp, w_sh_wicp;
   logic [TMPC_CWIDTH-1:0] r_tmpc, w_sh_tmpc;
   logic [POST_CWIDTH-1:0] r_post, w_sh_post;

   assign w_acc = bus.in_valid && r_in_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = 1'b0;
      w_issue     = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         LOAD: begin
            if (w_acc) begin
               w_we = 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  w_cnt_nxt = '0;
                  if (bus.in_last) w_state_nxt = ISSUE;
                  else             w_err_nxt   = 1'b1;
               end else if (bus.in_last) begin
                  w_cnt_nxt = '0;
                  w_err_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ISSUE: begin
            if (!bus.cfg_busy && !r_cfg_valid) begin
               w_issue     = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   // in_ready is registered so it stays low throughout reset and rises one cycle after release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= LOAD;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_cfg_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_data      <= '0;
         r_wicp      <= '0;
         r_tmpc      <= '0;
         r_post      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_in_ready  <= (w_state_nxt == LOAD);
         r_cfg_valid <= w_issue;
         r_frame_err <= w_err_nxt;
         if (w_issue) begin
            r_data <= w_sh_data;
            r_wicp <= w_sh_wicp;
            r_tmpc <= w_sh_tmpc;
            r_post <= w_sh_post;
         end
      end
   end

   cfg_field_shift #(.FWIDTH(DATA_CWIDTH), .IWIDTH(IWIDTH), .OFF(DATA_OFF), .CW(CW)) u_data (
      .clk(clk), .rst_n(rst_n), .i_we(w_we), .i_cnt(r_cnt), .i_data(bus.in_data), .o_q(w_sh_data)
   );
   cfg_field_shift #(.FWIDTH(WICP_CWIDTH), .IWIDTH(IWIDTH), .OFF(wicp_off(DW)), .CW(CW)) u_wicp (
      .clk(clk), .rst_n(rst_n), .i_we(w_we), .i_cnt(r_cnt), .i_data(bus.in_data), .o_q(w_sh_wicp)
   );
   cfg_field_shift #(.FWIDTH(TMPC_CWIDTH), .IWIDTH(IWIDTH), .OFF(tmpc_off(DW, WW)), .CW(CW)) u_tmpc (
      .clk(clk), .rst_n(rst_n), .i_we(w_we), .i_cnt(r_cnt), .i_data(bus.in_data), .o_q(w_sh_tmpc)
   );
   cfg_field_shift #(.FWIDTH(POST_CWIDTH), .IWIDTH(IWIDTH), .OFF(post_off(DW, WW, TW)), .CW(CW)) u_post (
      .clk(clk), .rst_n(rst_n), .i_we(w_we), .i_cnt(r_cnt), .i_data(bus.in_data), .o_q(w_sh_post)
   );

   assign bus.in_ready      = r_in_ready;
   assign bus.cfg_valid     = r_cfg_valid;
   assign bus.frame_err     = r_frame_err;
   assign bus.cfg_data_data = r_data;
   assign bus.cfg_wicp_data = r_wicp;
   assign bus.cfg_tmpc_data = r_tmpc;
   assign bus.cfg_post_data = r_post;
endmodule
